// File: rtl/counter_pipe_reader_pkg.sv
// Shared constants and types for counter_pipe_reader and its word unpacker.
// Optional build macro used by the top: COUNTER_PIPE_READER_FILL_EN.
package counter_pipe_reader_pkg;

    localparam int          LANES             = 4;
    localparam int          LANE_W            = 16;
    localparam int          LANE_IDX_W        = 2;
    localparam logic [15:0] FILL_WORD_DEFAULT = 16'hFFFF;

    typedef enum logic {
        BLK_IDLE = 1'b0,
        BLK_XFER = 1'b1
    } blk_state_e;

endpackage

// File: rtl/counter_pipe_reader_word_unpacker.sv
// Purpose: pops 64-bit FIFO words into a cur/nxt pair and presents them lane by lane.
// Latency: FIFO non-empty to valid lane is 2 cycles (pop strobe, then load).
// Backpressure: pops only with a free slot and no read in flight; consume_i advances the lane.
module word_unpacker
    import counter_pipe_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       fifo_dout_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    input  logic              consume_i,
    output logic              cur_vld_o,
    output logic [LANE_W-1:0] lane_dat_o,
    output logic [3:0]        buf_lanes_o
);

    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

    logic [63:0]           cur_q, cur_d, nxt_q, nxt_d;
    logic                  cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
    logic [LANE_IDX_W-1:0] lane_q, lane_d;
    logic                  rd_pending_q;

    // Gated by reset so the pop strobe is low while the block is held in reset.
    assign fifo_rd_en_o = rst_n && !fifo_empty_i && !rd_pending_q && !(cur_vld_q && nxt_vld_q);

    assign cur_vld_o   = cur_vld_q;
    assign lane_dat_o  = cur_q[{lane_q, 4'b0000} +: LANE_W];
    assign buf_lanes_o = {1'b0, cur_vld_q, 2'b00} + {1'b0, nxt_vld_q, 2'b00} - {2'b00, lane_q};

    always_comb begin
        cur_d     = cur_q;
        nxt_d     = nxt_q;
        cur_vld_d = cur_vld_q;
        nxt_vld_d = nxt_vld_q;
        lane_d    = lane_q;
        if (consume_i && cur_vld_q) begin
            if (lane_q == LAST_LANE) begin
                lane_d    = '0;
                cur_d     = nxt_q;
                cur_vld_d = nxt_vld_q;
                nxt_vld_d = 1'b0;
            end else begin
                lane_d = lane_q + 2'd1;
            end
        end
        // Returned word lands in whichever slot is free after this edge's release.
        if (rd_pending_q) begin
            if (!cur_vld_d) begin
                cur_d     = fifo_dout_i;
                cur_vld_d = 1'b1;
            end else begin
                nxt_d     = fifo_dout_i;
                nxt_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q        <= '0;
            nxt_q        <= '0;
            cur_vld_q    <= 1'b0;
            nxt_vld_q    <= 1'b0;
            lane_q       <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            cur_q        <= cur_d;
            nxt_q        <= nxt_d;
            cur_vld_q    <= cur_vld_d;
            nxt_vld_q    <= nxt_vld_d;
            lane_q       <= lane_d;
            rd_pending_q <= fifo_rd_en_o;
        end
    end

endmodule

// File: rtl/counter_pipe_reader.sv
// Purpose: counters result FIFO reader feeding the host block-pipe 16 bits at a time (macro COUNTER_PIPE_READER_FILL_EN pads underflows).
// Latency: pipe_dout valid 2 cycles after FIFO non-empty; pipe_block_ready 1 cycle after the block threshold.
// Backpressure: host paces with pipe_read; a read with nothing buffered flags sticky underflow.
module counter_pipe_reader
    import counter_pipe_reader_pkg::*;
#(
    parameter int          BLOCK_WORDS = 256,
    parameter int          COUNT_W     = 12,
    parameter logic [15:0] FILL_WORD   = FILL_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [63:0]        fifo_dout,
    input  logic               fifo_empty,
    input  logic [COUNT_W-1:0] fifo_rd_count,
    output logic               fifo_rd_en,
    input  logic               pipe_read,
    output logic [15:0]        pipe_dout,
    output logic               pipe_block_ready,
    input  logic               clear,
    output logic [31:0]        words_sent,
    output logic               underflow
);

    localparam int AVAIL_W = COUNT_W + 3;
    localparam int REM_W   = $clog2(BLOCK_WORDS) + 1;
    localparam logic [AVAIL_W-1:0] BLOCK_AVAIL = AVAIL_W'(BLOCK_WORDS);
    localparam logic [REM_W-1:0]   BLOCK_REM   = REM_W'(BLOCK_WORDS);
    localparam logic [REM_W-1:0]   REM_ONE     = REM_W'(1);

`ifdef COUNTER_PIPE_READER_FILL_EN
    localparam logic FILL_EN = 1'b1;
`else
    localparam logic FILL_EN = 1'b0;
`endif

    logic               cur_vld;
    logic [15:0]        lane_dat;
    logic [3:0]         buf_lanes;
    logic [AVAIL_W-1:0] avail;
    logic [15:0]        fill_dat;

    blk_state_e         state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [31:0]        words_sent_q, words_sent_d;
    logic               underflow_q, underflow_d;

    word_unpacker u_unpacker (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_dout_i  (fifo_dout),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .consume_i    (pipe_read),
        .cur_vld_o    (cur_vld),
        .lane_dat_o   (lane_dat),
        .buf_lanes_o  (buf_lanes)
    );

    // A popped word still in flight is counted in neither term; that only delays the start.
    assign avail    = {1'b0, fifo_rd_count, 2'b00} + AVAIL_W'(buf_lanes);
    assign fill_dat = FILL_EN ? FILL_WORD : 16'h0000;
    assign pipe_dout = cur_vld ? lane_dat : fill_dat;

    assign pipe_block_ready = (state_q == BLK_XFER);
    assign words_sent       = words_sent_q;
    assign underflow        = underflow_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            BLK_IDLE: begin
                if (avail >= BLOCK_AVAIL) begin
                    state_d = BLK_XFER;
                    rem_d   = BLOCK_REM;
                end
            end
            BLK_XFER: begin
                // Underflowing reads still count so the host's block framing holds.
                if (pipe_read) begin
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = BLK_IDLE;
                    end
                end
            end
            default: state_d = BLK_IDLE;
        endcase
    end

    always_comb begin
        words_sent_d = words_sent_q;
        underflow_d  = underflow_q;
        if (clear) begin
            words_sent_d = '0;
            underflow_d  = 1'b0;
        end else if (pipe_read) begin
            if (cur_vld || FILL_EN) begin
                words_sent_d = words_sent_q + 32'd1;
            end
            if (!cur_vld) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BLK_IDLE;
            rem_q        <= '0;
            words_sent_q <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            words_sent_q <= words_sent_d;
            underflow_q  <= underflow_d;
        end
    end

endmodule

// File: tb/tb_counter_pipe_reader.sv
// Directed bench for counter_pipe_reader with a behavioural non-FWFT FIFO on its read port.
// Honours COUNTER_PIPE_READER_FILL_EN for the fill-dependent expectations.
`timescale 1ns/1ps
module tb_counter_pipe_reader;

    localparam int          COUNT_W = 12;
    localparam logic [63:0] BASE    = 64'h0001_0002_0003_0004;
`ifdef COUNTER_PIPE_READER_FILL_EN
    localparam logic        FILL_EN = 1'b1;
`else
    localparam logic        FILL_EN = 1'b0;
`endif
    localparam logic [15:0] EXP_FILL = FILL_EN ? 16'hFFFF : 16'h0000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [63:0]        fifo_dout;
    logic               fifo_empty;
    logic [COUNT_W-1:0] fifo_rd_count;
    logic               fifo_rd_en;
    logic               pipe_read;
    logic [15:0]        pipe_dout;
    logic               pipe_block_ready;
    logic               clear;
    logic [31:0]        words_sent;
    logic               underflow;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] fq[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          wcnt = 0;
    int          pops = 0;

    always #5 clk = ~clk;

    counter_pipe_reader #(
        .BLOCK_WORDS (256),
        .COUNT_W     (COUNT_W),
        .FILL_WORD   (16'hFFFF)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fifo_dout        (fifo_dout),
        .fifo_empty       (fifo_empty),
        .fifo_rd_count    (fifo_rd_count),
        .fifo_rd_en       (fifo_rd_en),
        .pipe_read        (pipe_read),
        .pipe_dout        (pipe_dout),
        .pipe_block_ready (pipe_block_ready),
        .clear            (clear),
        .words_sent       (words_sent),
        .underflow        (underflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, req);
        end
    endtask

    task automatic sync_flags();
        fifo_empty    = (fq.size() == 0);
        fifo_rd_count = COUNT_W'(fq.size());
    endtask

    task automatic push_words(input int n);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = BASE + 64'(wcnt);
            wcnt++;
            fq.push_back(w);
            for (int l = 0; l < 4; l++) exp_q.push_back(w[l*16 +: 16]);
        end
        sync_flags();
    endtask

    // One clock: sample strobes before the edge, model the FIFO read port after it.
    task automatic step();
        logic pop;
        #1;
        pop = fifo_rd_en;
        if (pipe_read) got_q.push_back(pipe_dout);
        @(posedge clk);
        #1;
        if (pop && fq.size() > 0) begin
            fifo_dout = fq.pop_front();
            pops++;
        end
        sync_flags();
        #1;
    endtask

    task automatic run_reads(input int n, output int rdy_hi);
        rdy_hi = 0;
        for (int i = 0; i < n; i++) begin
            pipe_read = 1'b1;
            if (pipe_block_ready) rdy_hi++;
            step();
        end
        pipe_read = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (!pipe_block_ready && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, pipe_block_ready, 1'b1);
    endtask

    task automatic check_seq(input string tag, input int n);
        check_eq({tag, "_len"}, got_q.size(), n);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check_eq(tag, got_q[i], exp_q[i]);
    endtask

    task automatic restart_queues();
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, hi2, pops0;
        logic [31:0] ws0;

        rst_n = 1'b0; pipe_read = 1'b0; clear = 1'b0; fifo_dout = '0;
        sync_flags();
        #3;
        check_eq("rst_rd_en", fifo_rd_en, 1'b0);
        check_eq("rst_dout", pipe_dout, EXP_FILL);
        check_eq("rst_rdy", pipe_block_ready, 1'b0);
        check_eq("rst_ws", words_sent, 32'd0);
        check_eq("rst_uf", underflow, 1'b0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Full block from 64 buffered words, host reading every cycle.
        restart_queues();
        push_words(64);
        step();
        check_eq("t1_rdy_1cyc", pipe_block_ready, 1'b1);
        check_eq("t1_dout_1cyc", pipe_dout, EXP_FILL);
        step();
        check_eq("t1_lat2", pipe_dout, 16'h0004);
        run_reads(256, hi);
        check_eq("t1_rdy_held", hi, 256);
        check_eq("t1_rdy_fall", pipe_block_ready, 1'b0);
        check_eq("t1_w0", got_q[0], 16'h0004);
        check_eq("t1_w1", got_q[1], 16'h0003);
        check_eq("t1_w3", got_q[3], 16'h0001);
        check_eq("t1_w4", got_q[4], 16'h0005);
        check_seq("t1_seq", 256);
        check_eq("t1_uf", underflow, 1'b0);
        check_eq("t1_ws", words_sent, 32'd256);

        // 63 words stay below threshold; the 64th starts a block.
        restart_queues();
        push_words(63);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (pipe_block_ready) hi++;
            step();
        end
        check_eq("t2_below", hi + int'(pipe_block_ready), 0);
        push_words(1);
        wait_ready("t2_rdy", 2);
        run_reads(256, hi);
        check_eq("t2_rdy_held", hi, 256);
        check_eq("t2_rdy_fall", pipe_block_ready, 1'b0);
        check_seq("t2_seq", 256);
        check_eq("t2_uf", underflow, 1'b0);
        check_eq("t2_ws", words_sent, 32'd512);

        // FIFO drained mid-block: underflow, block framing still 256 reads.
        restart_queues();
        pops0 = pops;
        ws0 = words_sent;
        push_words(64);
        step(); step();
        check_eq("t3_rdy", pipe_block_ready, 1'b1);
        run_reads(200, hi);
        check_eq("t3_uf_early", underflow, 1'b0);
        fq.delete();
        sync_flags();
        run_reads(56, hi2);
        check_eq("t3_rdy_held", hi + hi2, 256);
        check_eq("t3_rdy_fall", pipe_block_ready, 1'b0);
        check_eq("t3_uf", underflow, 1'b1);
        check_eq("t3_dout", pipe_dout, EXP_FILL);
        check_eq("t3_ws", words_sent - ws0, FILL_EN ? 32'd256 : 32'(4 * (pops - pops0)));

        // clear coinciding with a read: counter zeroed, word still delivered.
        restart_queues();
        push_words(4);
        step(); step(); step();
        check_eq("t5_pre", pipe_dout, exp_q[0]);
        clear = 1'b1; pipe_read = 1'b1;
        step();
        clear = 1'b0; pipe_read = 1'b0;
        check_eq("t5_ws0", words_sent, 32'd0);
        check_eq("t5_uf0", underflow, 1'b0);
        check_eq("t5_next", pipe_dout, exp_q[1]);
        run_reads(15, hi);
        check_eq("t5_ws", words_sent, 32'd15);
        check_seq("t5_seq", 16);

        // Host reading every other cycle while the FIFO is refilled.
        restart_queues();
        push_words(8);
        step(); step(); step();
        for (int i = 0; i < 200; i++) begin
            pipe_read = i[0];
            if (i % 8 == 0) push_words(1);
            step();
        end
        pipe_read = 1'b0;
        check_seq("t4_seq", 100);
        check_eq("t4_uf", underflow, 1'b0);
        check_eq("t4_ws", words_sent, 32'd115);

        // Reset in the middle of a block, then a fresh block.
        push_words(64);
        wait_ready("t6_rdy", 3);
        step(); step();
        run_reads(100, hi);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_rdy", pipe_block_ready, 1'b0);
        check_eq("t6_rst_ws", words_sent, 32'd0);
        check_eq("t6_rst_uf", underflow, 1'b0);
        check_eq("t6_rst_dout", pipe_dout, EXP_FILL);
        check_eq("t6_rst_rd_en", fifo_rd_en, 1'b0);
        fq.delete();
        sync_flags();
        step(); step();
        rst_n = 1'b1;
        step();
        restart_queues();
        push_words(64);
        step();
        check_eq("t6_rdy_again", pipe_block_ready, 1'b1);
        step();
        check_eq("t6_first", pipe_dout, exp_q[0]);
        run_reads(256, hi);
        check_eq("t6_rdy_held", hi, 256);
        check_eq("t6_rdy_fall", pipe_block_ready, 1'b0);
        check_seq("t6_seq", 256);
        check_eq("t6_ws", words_sent, 32'd256);
        check_eq("t6_uf", underflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
